// File: rtl/mdu_seq_if.sv
// EX-stage request/response bundle for the multiply/divide sequencer.
interface mdu_seq_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Stall;
  logic             RdValid;
  logic [WIDTH-1:0] RdData;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output Start, Op, A, B,
                  input  Busy, Stall, RdValid, RdData, Hi, Lo);
  modport slave  (input  Start, Op, A, B,
                  output Busy, Stall, RdValid, RdData, Hi, Lo);
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/DIV sequencer with architectural HI/LO. Operates on magnitudes
// and applies the sign correction in a final FIX cycle.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  mdu_seq_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [W2-1:0]    acc;     // MUL: {product hi, multiplier/product lo}; DIV: {rem, quo}
  logic [WIDTH-1:0] opd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] araw;
  logic [WIDTH-1:0] hi, lo;
  logic             rsign, remsign, div0, isdiv, busy;

  logic             accept, sgn_op, no_borrow;
  logic [WIDTH-1:0] abs_a, abs_b, diff, quo_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [W2-1:0]    prod_fix;

  always_comb begin
    accept    = bus.Start & (state == IDLE);
    sgn_op    = ~bus.Op[2] & bus.Op[0];
    abs_a     = (sgn_op & bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b     = (sgn_op & bus.B[WIDTH-1]) ? -bus.B : bus.B;
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    rem_sh    = acc[W2-1:WIDTH-1];
    no_borrow = rem_sh >= {1'b0, opd};
    // True difference is < 2^WIDTH whenever it is kept, so low bits suffice.
    diff      = rem_sh[WIDTH-1:0] - opd;
    prod_fix  = rsign ? -acc : acc;
    quo_fix   = rsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = remsign ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  end

  assign bus.Busy    = busy;
  assign bus.Stall   = bus.Start & busy;
  assign bus.RdValid = accept & (bus.Op[2:1] == 2'b11);
  assign bus.RdData  = bus.Op[0] ? lo : hi;
  assign bus.Hi      = hi;
  assign bus.Lo      = lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opd     <= '0;
      araw    <= '0;
      hi      <= '0;
      lo      <= '0;
      rsign   <= 1'b0;
      remsign <= 1'b0;
      div0    <= 1'b0;
      isdiv   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (bus.Op)
            3'b100: hi <= bus.A;
            3'b101: lo <= bus.A;
            3'b110, 3'b111: ;
            default: begin
              araw    <= bus.A;
              opd     <= bus.Op[1] ? abs_b : abs_a;
              acc     <= {{WIDTH{1'b0}}, bus.Op[1] ? abs_a : abs_b};
              rsign   <= sgn_op & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              remsign <= sgn_op & bus.A[WIDTH-1];
              div0    <= (bus.B == '0);
              isdiv   <= bus.Op[1];
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= bus.Op[1] ? DIV : MUL;
            end
          endcase
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH - 1)) state <= FIX;
        end
        DIV: begin
          acc <= no_borrow ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[W2-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!isdiv) begin
            hi <= prod_fix[W2-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div0) begin
            hi <= araw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Randomized and directed checks of mdu_seq against an arithmetic HI/LO model.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(32)) bus ();
  mdu_seq #(.WIDTH(32), .CNTW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference result of a MULT*/DIV* op using plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      3'b001: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'b010: if (b == 0) begin h = a; l = '1; end else begin h = a % b; l = a / b; end
      default: if (b == 0) begin h = a; l = '1; end
               else begin h = 32'(sa % sb); l = 32'(sa / sb); end
    endcase
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    @(posedge clk); #1 bus.Start = 1'b0;
  endtask

  // Returns busy-cycle count; leaves time at the first negedge with Busy low.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (bus.Busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset;
    int n;
    bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
    #12;
    total++; if (bus.Busy !== 1'b0 || bus.Stall !== 1'b0 || bus.RdValid !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got busy=%b stall=%b rdv=%b want 0 0 0", bus.Busy, bus.Stall, bus.RdValid); end
    total++; if (bus.Hi !== 32'h0 || bus.Lo !== 32'h0) begin
      bad++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.Hi, bus.Lo); end
    @(negedge clk) rst_n = 1'b1;
    issue(3'b000, 32'd5, 32'd7);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_abort_busy got %b want 0", bus.Busy); end
    @(negedge clk) rst_n = 1'b1;
    drive(3'b111, '0, '0);
    #1;
    total++; if (bus.RdValid !== 1'b1 || bus.RdData !== 32'h0 || bus.Hi !== 32'h0) begin
      bad++; $display("FAIL reset_mflo got rdv=%b data=%h hi=%h want 1 0 0", bus.RdValid, bus.RdData, bus.Hi); end
    @(posedge clk); #1 bus.Start = 1'b0;
    wait_idle(n);
    total++; if (n !== 0) begin bad++; $display("FAIL reset_idle got busy_cycles=%0d want 0", n); end
    mhi = '0; mlo = '0;
  endtask

  task automatic test_multu;
    int n;
    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (n !== 33) begin bad++; $display("FAIL multu_latency got %0d want 33", n); end
    total++; if (bus.Hi !== 32'hFFFFFFFE || bus.Lo !== 32'h00000001) begin
      bad++; $display("FAIL multu_result got %h/%h want fffffffe/00000001", bus.Hi, bus.Lo); end
    // New request in the first idle cycle.
    bus.Start = 1'b1; bus.Op = 3'b110;
    #1;
    total++; if (bus.RdValid !== 1'b1 || bus.RdData !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL multu_mfhi got rdv=%b data=%h want 1 fffffffe", bus.RdValid, bus.RdData); end
    @(posedge clk); #1 bus.Start = 1'b0;
    mhi = 32'hFFFFFFFE; mlo = 32'h1;
  endtask

  task automatic test_mult;
    int n;
    issue(3'b001, 32'hFFFFFFF9, 32'd6);
    repeat (10) @(negedge clk);
    total++; if (bus.Hi !== mhi || bus.Lo !== mlo) begin
      bad++; $display("FAIL mult_hold got %h/%h want %h/%h", bus.Hi, bus.Lo, mhi, mlo); end
    wait_idle(n);
    total++; if (bus.Hi !== 32'hFFFFFFFF || bus.Lo !== 32'hFFFFFFD6) begin
      bad++; $display("FAIL mult_result got %h/%h want ffffffff/ffffffd6", bus.Hi, bus.Lo); end
    mhi = 32'hFFFFFFFF; mlo = 32'hFFFFFFD6;
  endtask

  task automatic test_div;
    int n;
    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++; if (bus.Hi !== 32'hFFFFFFFF || bus.Lo !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_result got %h/%h want ffffffff/fffffffd", bus.Hi, bus.Lo); end
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (bus.Hi !== 32'h0 || bus.Lo !== 32'h80000000) begin
      bad++; $display("FAIL div_overflow got %h/%h want 00000000/80000000", bus.Hi, bus.Lo); end
    issue(3'b011, 32'hFFFFFF00, 32'h0);
    wait_idle(n);
    total++; if (bus.Hi !== 32'hFFFFFF00 || bus.Lo !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL div_zero_signed got %h/%h want ffffff00/ffffffff", bus.Hi, bus.Lo); end
    mhi = 32'hFFFFFF00; mlo = 32'hFFFFFFFF;
  endtask

  task automatic test_stall;
    int n;
    issue(3'b010, 32'd100, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 3'b110; bus.A = '0; bus.B = '0;
    #1;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      total++; if (bus.Stall !== 1'b1 || bus.RdValid !== 1'b0) begin
        bad++; $display("FAIL stall_cycle%0d got stall=%b rdv=%b want 1 0", n, bus.Stall, bus.RdValid); end
      n++;
      @(negedge clk); #1;
    end
    total++; if (n !== 29) begin bad++; $display("FAIL stall_count got %0d want 29", n); end
    total++; if (bus.Stall !== 1'b0 || bus.RdValid !== 1'b1 || bus.RdData !== 32'd100 || bus.Lo !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL stall_release got stall=%b rdv=%b data=%h lo=%h want 0 1 00000064 ffffffff",
                      bus.Stall, bus.RdValid, bus.RdData, bus.Lo); end
    @(posedge clk); #1 bus.Start = 1'b0;
    mhi = 32'd100; mlo = 32'hFFFFFFFF;
  endtask

  task automatic test_back_to_back;
    drive(3'b101, 32'h12345678, '0);
    #1;
    total++; if (bus.Stall !== 1'b0) begin bad++; $display("FAIL b2b_mtlo_stall got %b want 0", bus.Stall); end
    drive(3'b111, '0, '0);
    #1;
    total++; if (bus.RdValid !== 1'b1 || bus.RdData !== 32'h12345678 || bus.Stall !== 1'b0) begin
      bad++; $display("FAIL b2b_mflo got rdv=%b data=%h stall=%b want 1 12345678 0", bus.RdValid, bus.RdData, bus.Stall); end
    @(posedge clk); #1 bus.Start = 1'b0;
    mlo = 32'h12345678;
  endtask

  task automatic test_random;
    int n;
    logic [2:0] op;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      if (op[2] == 1'b0) begin
        model(op, a, b, eh, el);
        issue(op, a, b);
        wait_idle(n);
        total++; if (n !== 33 || bus.Hi !== eh || bus.Lo !== el) begin
          bad++; $display("FAIL rand%0d_op%0d a=%h b=%h got n=%0d %h/%h want 33 %h/%h",
                          i, op, a, b, n, bus.Hi, bus.Lo, eh, el); end
        mhi = eh; mlo = el;
      end else if (op[1] == 1'b0) begin
        issue(op, a, b);
        if (op[0]) mlo = a; else mhi = a;
        @(negedge clk);
        total++; if (bus.Hi !== mhi || bus.Lo !== mlo) begin
          bad++; $display("FAIL rand%0d_mt got %h/%h want %h/%h", i, bus.Hi, bus.Lo, mhi, mlo); end
      end else begin
        drive(op, a, b);
        #1;
        total++; if (bus.RdValid !== 1'b1 || bus.RdData !== (op[0] ? mlo : mhi)) begin
          bad++; $display("FAIL rand%0d_mf got rdv=%b data=%h want 1 %h", i, bus.RdValid, bus.RdData,
                          op[0] ? mlo : mhi); end
        @(posedge clk); #1 bus.Start = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_stall;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
